// File: rtl/tbus_reader.sv
// -----------------------------------------------------------------------------
// tbus_reader
//
// Listener side of a shared, inverted-polarity parallel bus with a four-phase
// strobe handshake. A word is captured on each strobe rise and checked for odd
// parity. A good word goes into a small receive FIFO and is answered with ACK.
// A word with bad parity, or a word that arrives while the FIFO is full, is
// answered with NAK. Sticky PERR and OVF flags record why words were rejected.
//
// Handshake contract:
//   Talker side (four-phase): the talker drives BUS_D and BUS_P, then raises
//   BUS_STB. It holds them until it sees BUS_ACK or BUS_NAK, then lowers
//   BUS_STB. The reader holds ACK or NAK until it samples the strobe low.
//   Consumer side (valid/ready): the head word Y is transferred on every rising
//   edge where VALID && READY. VALID never depends on READY.
//
// Parameters:
//   W     - bus data width
//   DEPTH - receive FIFO depth (power of 2, >= 2)
//
// Ports:
//   CLK       in   clock, rising edge
//   R         in   asynchronous active-low reset
//   BUS_D     in   [W-1:0] bus data, inverted on the wire
//   BUS_P     in   parity line, inverted on the wire
//   BUS_STB   in   talker strobe, active high
//   BUS_ACK   out  word accepted (registered)
//   BUS_NAK   out  word rejected (registered)
//   Y         out  [W-1:0] FIFO head word, logical polarity
//   VALID     out  FIFO non-empty
//   READY     in   consumer pops the head when VALID && READY
//   COUNT     out  [clog2(DEPTH):0] FIFO occupancy
//   CLR       in   synchronous clear of the FIFO and the sticky flags
//   PERR      out  sticky parity-error flag
//   OVF       out  sticky overflow flag
//   DBG_STATE out  [1:0] FSM state, for monitors
// -----------------------------------------------------------------------------
module tbus_reader #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       R,
    input  logic [W-1:0]               BUS_D,
    input  logic                       BUS_P,
    input  logic                       BUS_STB,
    output logic                       BUS_ACK,
    output logic                       BUS_NAK,
    output logic [W-1:0]               Y,
    output logic                       VALID,
    input  logic                       READY,
    output logic [$clog2(DEPTH):0]     COUNT,
    input  logic                       CLR,
    output logic                       PERR,
    output logic                       OVF,
    output logic [1:0]                 DBG_STATE
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_NAK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input sampling stage. Every decision below uses only these
    // registers, never the raw bus pins.
    // ------------------------------------------------------------------
    logic [W-1:0] r_bus_d_s;
    logic         r_bus_p_s;
    logic         r_stb_s;
    logic         r_stb_prev;

    // Both strobe registers come out of reset high so that a strobe that is
    // already high when reset is released does not look like a new rise.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_bus_d_s  <= '0;
            r_bus_p_s  <= 1'b0;
            r_stb_s    <= 1'b1;
            r_stb_prev <= 1'b1;
        end else begin
            r_bus_d_s  <= BUS_D;
            r_bus_p_s  <= BUS_P;
            r_stb_s    <= BUS_STB;
            r_stb_prev <= r_stb_s;
        end
    end

    logic         w_stb_rise;
    logic [W-1:0] w_word;
    logic         w_par;
    logic         w_par_good;

    assign w_stb_rise = r_stb_s & ~r_stb_prev;
    assign w_word     = ~r_bus_d_s;
    assign w_par      = ~r_bus_p_s;
    assign w_par_good = ^{w_word, w_par};

    // ------------------------------------------------------------------
    // FIFO storage state (declared here because the FSM judges fullness)
    // ------------------------------------------------------------------
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_valid;
    assign w_full  = (r_count == DEPTH_C);
    assign w_valid = (r_count != '0);

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_push;
    logic   w_perr_set;
    logic   w_ovf_set;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Parity is checked before fullness: a bad word into a full FIFO is a
    // parity error, not an overflow. Fullness uses the occupancy before any
    // pop in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr_set  = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_stb_rise) begin
                    if (!w_par_good) begin
                        w_perr_set  = 1'b1;
                        w_state_nxt = ST_NAK;
                    end else if (w_full) begin
                        w_ovf_set   = 1'b1;
                        w_state_nxt = ST_NAK;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_ACK, ST_NAK: begin
                if (!r_stb_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ACK/NAK are decoded straight from the state register, so they are
    // glitch-free and drop as soon as reset is asserted.
    assign BUS_ACK   = (r_state == ST_ACK);
    assign BUS_NAK   = (r_state == ST_NAK);
    assign DBG_STATE = r_state;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic w_pop;
    assign w_pop = w_valid & READY;

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (w_push && !CLR) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their
    // own. CLR overrides both push and pop.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (CLR) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a clear in the same cycle as a set wins.
    // ------------------------------------------------------------------
    logic r_perr;
    logic r_ovf;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_perr <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (CLR) begin
            r_perr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_perr_set) begin
                r_perr <= 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign PERR  = r_perr;
    assign OVF   = r_ovf;
    assign COUNT = r_count;
    assign VALID = w_valid;
    // Forced to zero while empty so that Y reads 0 during and after reset.
    assign Y     = w_valid ? r_mem[r_rptr] : '0;

endmodule

// File: tb/tb_tbus_reader.sv
// -----------------------------------------------------------------------------
// tb_tbus_reader
//
// Directed bench for tbus_reader (W=8, DEPTH=4). Inputs change 1 ns after the
// rising edge, and outputs are read there or on the falling edge. The bus is
// inverted on the wire, so a logical word d is driven as BUS_D = ~d. With
// odd parity, the logical parity bit is ~^d, so good parity on the wire is
// BUS_P = ^d. For example, A5 on the wire carries 5A, which has four ones.
// That needs logical parity 1, which is BUS_P = 0.
// -----------------------------------------------------------------------------
module tb_tbus_reader;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] bus_d;
  logic         bus_p;
  logic         bus_stb;
  logic         bus_ack;
  logic         bus_nak;
  logic [W-1:0] y;
  logic         valid;
  logic         ready;
  logic [2:0]   count;
  logic         clr;
  logic         perr;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;

  tbus_reader #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK       (clk),
    .R         (rst_n),
    .BUS_D     (bus_d),
    .BUS_P     (bus_p),
    .BUS_STB   (bus_stb),
    .BUS_ACK   (bus_ack),
    .BUS_NAK   (bus_nak),
    .Y         (y),
    .VALID     (valid),
    .READY     (ready),
    .COUNT     (count),
    .CLR       (clr),
    .PERR      (perr),
    .OVF       (ovf),
    .DBG_STATE (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_word(input logic [W-1:0] d, input logic good);
    bus_d = ~d;
    bus_p = good ? ^d : ~(^d);
  endtask

  // Full four-phase handshake with bounded waits.
  task automatic hs(input logic [W-1:0] d, input logic good, output logic ack, output logic nak);
    drive_word(d, good);
    bus_stb = 1'b1;
    for (int i = 0; i < 10 && !(bus_ack || bus_nak); i++) tick();
    ack = bus_ack;
    nak = bus_nak;
    check("hs_response", {31'b0, ack | nak}, 32'd1);
    bus_stb = 1'b0;
    for (int i = 0; i < 10 && (bus_ack || bus_nak); i++) tick();
    check("hs_release", {31'b0, bus_ack | bus_nak}, 32'd0);
    tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // scoreboard: checks each popped word against the expected queue
  always @(negedge clk) begin
    if (mon_en) begin
      check("count_max", {31'b0, count <= 3'd4}, 32'd1);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'd1, 32'd0);
        end else begin
          check("pop_order", {24'b0, y}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  logic ack, nak;

  initial begin
    rst_n   = 1'b0;
    bus_d   = '1;
    bus_p   = 1'b1;
    bus_stb = 1'b0;
    ready   = 1'b0;
    clr     = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_ack",   {31'b0, bus_ack}, 32'd0);
    check("rst_nak",   {31'b0, bus_nak}, 32'd0);
    check("rst_count", {29'b0, count},   32'd0);
    check("rst_valid", {31'b0, valid},   32'd0);
    check("rst_perr",  {31'b0, perr},    32'd0);
    check("rst_ovf",   {31'b0, ovf},     32'd0);
    check("rst_y",     {24'b0, y},       32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single good word, exact latency (A5 on wire, parity line 0 = good)
    bus_d   = 8'hA5;
    bus_p   = 1'b0;
    bus_stb = 1'b1;
    tick();
    check("lat_ack_t", {31'b0, bus_ack}, 32'd0);
    tick();
    check("lat_ack_t1", {31'b0, bus_ack}, 32'd1);
    repeat (3) tick();
    check("ack_held", {31'b0, bus_ack}, 32'd1);
    check("y_5a",     {24'b0, y},       32'h5A);
    check("valid_1",  {31'b0, valid},   32'd1);
    check("count_1",  {29'b0, count},   32'd1);
    bus_stb = 1'b0;
    tick();
    check("ack_still_sampling", {31'b0, bus_ack}, 32'd1);
    tick();
    check("ack_dropped", {31'b0, bus_ack}, 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pop_valid", {31'b0, valid}, 32'd0);
    check("pop_count", {29'b0, count}, 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pop_empty_count", {29'b0, count}, 32'd0);

    // bad parity: A5 with parity line 1
    bus_d = 8'hA5;
    bus_p = 1'b1;
    bus_stb = 1'b1;
    repeat (2) tick();
    check("perr_nak",   {31'b0, bus_nak}, 32'd1);
    check("perr_ack",   {31'b0, bus_ack}, 32'd0);
    check("perr_flag",  {31'b0, perr},    32'd1);
    check("perr_count", {29'b0, count},   32'd0);
    bus_stb = 1'b0;
    repeat (3) tick();
    pulse_clr();
    check("perr_clr", {31'b0, perr}, 32'd0);

    // fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) begin
      hs(8'(i), 1'b1, ack, nak);
      check("fill_ack", {31'b0, ack}, 32'd1);
    end
    check("full_count", {29'b0, count}, 32'd4);
    hs(8'h05, 1'b1, ack, nak);
    check("ovf_nak",   {31'b0, nak},   32'd1);
    check("ovf_flag",  {31'b0, ovf},   32'd1);
    check("ovf_count", {29'b0, count}, 32'd4);
    check("ovf_perr",  {31'b0, perr},  32'd0);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", {31'b0, valid}, 32'd1);
      check("drain_y", {24'b0, y}, i);
      tick();
    end
    ready = 1'b0;
    check("drain_empty", {31'b0, valid}, 32'd0);
    pulse_clr();
    check("ovf_clr", {31'b0, ovf}, 32'd0);

    // ten words across pointer wrap, with alternating consumer readiness
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ready = (i % 2) == 1;
      exp_q.push_back(8'(8'h30 + i));
      hs(8'(8'h30 + i), 1'b1, ack, nak);
      check("wrap_ack", {31'b0, ack}, 32'd1);
    end
    ready = 1'b1;
    for (int i = 0; i < 20 && valid; i++) tick();
    ready = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    #1;
    check("wrap_drained", {31'b0, valid}, 32'd0);
    check("wrap_q_empty", exp_q.size(), 32'd0);

    // reset in mid-handshake, strobe held across reset release
    drive_word(8'h77, 1'b1);
    bus_stb = 1'b1;
    repeat (2) tick();
    check("mid_ack", {31'b0, bus_ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",   {31'b0, bus_ack}, 32'd0);
    check("mid_rst_count", {29'b0, count},   32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("held_no_ack",  {31'b0, bus_ack}, 32'd0);
    check("held_no_nak",  {31'b0, bus_nak}, 32'd0);
    check("held_no_push", {29'b0, count},   32'd0);
    bus_stb = 1'b0;
    repeat (2) tick();
    hs(8'h77, 1'b1, ack, nak);
    check("rearm_ack",   {31'b0, ack},   32'd1);
    check("rearm_count", {29'b0, count}, 32'd1);
    check("rearm_y",     {24'b0, y},     32'h77);

    // full FIFO, push coinciding with a pop: still NAK
    for (int i = 2; i <= 4; i++) begin
      hs(8'(8'h70 + i), 1'b1, ack, nak);
    end
    check("full2_count", {29'b0, count}, 32'd4);
    drive_word(8'hEE, 1'b1);
    bus_stb = 1'b1;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("fullpop_nak",   {31'b0, bus_nak}, 32'd1);
    check("fullpop_ovf",   {31'b0, ovf},     32'd1);
    check("fullpop_count", {29'b0, count},   32'd3);
    check("fullpop_y",     {24'b0, y},       32'h72);
    bus_stb = 1'b0;
    repeat (3) tick();

    // CLR during a push: ACK is still given, the word is discarded
    pulse_clr();
    drive_word(8'h11, 1'b1);
    bus_stb = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrpush_ack",   {31'b0, bus_ack}, 32'd1);
    check("clrpush_count", {29'b0, count},   32'd0);
    bus_stb = 1'b0;
    repeat (3) tick();

    // CLR while a parity error is flagged: clear wins
    drive_word(8'h11, 1'b0);
    bus_stb = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrperr_nak",  {31'b0, bus_nak}, 32'd1);
    check("clrperr_perr", {31'b0, perr},    32'd0);
    bus_stb = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
